// File: rtl/acc_pkg.sv
// Shared types and constants for the accelerator accumulate engine.
package acc_pkg;

    // Address/size width is tied to the 6-bit command fields.
    localparam int unsigned ADDR_W     = 6;
    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_ACC_W  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/acc_addr_gen.sv
// Read address generator: loads start/size, then issues one address per
// enable, wrapping modulo 2^ADDR_W, and flags the final address of the walk.
module acc_addr_gen #(
    parameter int unsigned ADDR_W = acc_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] start_i,
    input  logic [ADDR_W-1:0] size_i,
    input  logic              en_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              last_o
);

    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W-1:0] rem_q, rem_d;
    logic [ADDR_W-1:0] cur_ptr;
    logic [ADDR_W-1:0] cur_rem;

    // Load bypasses the registers so the first address can be issued in the
    // same cycle the command is accepted.
    always_comb begin
        cur_ptr = load_i ? start_i : ptr_q;
        cur_rem = load_i ? size_i  : rem_q;
        addr_o  = cur_ptr;
        last_o  = (cur_rem == ADDR_W'(1));
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        if (en_i) begin
            ptr_d = cur_ptr + 1'b1;
            rem_d = cur_rem - 1'b1;
        end else if (load_i) begin
            ptr_d = start_i;
            rem_d = size_i;
        end
    end

    // Pointer and remaining-count registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
            rem_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            rem_q <= rem_d;
        end
    end

endmodule

// File: rtl/acc_engine.sv
// Accumulate engine: on an accepted command, reads datasize words starting at
// startaddr from local memory, sums them, and pulses accdone when finished.
module acc_engine #(
    parameter int unsigned DATA_W = acc_pkg::DEF_DATA_W,
    parameter int unsigned ACC_W  = acc_pkg::DEF_ACC_W,
    parameter int unsigned ADDR_W = acc_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    input  logic              accbypassA,
    input  logic [ADDR_W-1:0] startaddrA,
    input  logic [ADDR_W-1:0] datasizeA,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [ACC_W-1:0]  acc_result,
    output logic              busy,
    output logic              accdone
);

    import acc_pkg::*;

    state_e            state_q, state_d;
    logic              mem_rd_q, mem_rd_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic              busy_q, busy_d;
    logic              accdone_q, accdone_d;
    logic              rdv_q;
    logic              final_q, final_d;

    logic              gen_load;
    logic              gen_en;
    logic [ADDR_W-1:0] gen_addr;
    logic              gen_last;

    acc_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk     (clk),
        .reset   (reset),
        .load_i  (gen_load),
        .start_i (startaddrA),
        .size_i  (datasizeA),
        .en_i    (gen_en),
        .addr_o  (gen_addr),
        .last_o  (gen_last)
    );

    // Next-state, next-output and accumulator computation.
    // final_q marks that mem_addr_q already holds the last address of the
    // walk, so READ hands over to DRAIN on that cycle.
    always_comb begin
        state_d    = state_q;
        mem_rd_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        accdone_d  = 1'b0;
        final_d    = final_q;
        gen_load   = 1'b0;
        gen_en     = 1'b0;
        acc_d      = acc_q;
        if (rdv_q) begin
            acc_d = acc_q + ACC_W'(mem_rdata);
        end
        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    acc_d = '0;
                    if (accbypassA || (datasizeA == '0)) begin
                        state_d   = DONE;
                        accdone_d = 1'b1;
                    end else begin
                        state_d    = READ;
                        gen_load   = 1'b1;
                        gen_en     = 1'b1;
                        mem_rd_d   = 1'b1;
                        mem_addr_d = gen_addr;
                        final_d    = gen_last;
                    end
                end
            end
            READ: begin
                if (final_q) begin
                    state_d = DRAIN;
                    final_d = 1'b0;
                end else begin
                    gen_en     = 1'b1;
                    mem_rd_d   = 1'b1;
                    mem_addr_d = gen_addr;
                    final_d    = gen_last;
                end
            end
            DRAIN: begin
                state_d   = DONE;
                accdone_d = 1'b1;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // FSM state, registered outputs and read-valid pipeline.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            acc_q      <= '0;
            busy_q     <= 1'b0;
            accdone_q  <= 1'b0;
            rdv_q      <= 1'b0;
            final_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
            acc_q      <= acc_d;
            busy_q     <= busy_d;
            accdone_q  <= accdone_d;
            rdv_q      <= mem_rd_q;
            final_q    <= final_d;
        end
    end

    assign mem_rd     = mem_rd_q;
    assign mem_addr   = mem_addr_q;
    assign acc_result = acc_q;
    assign busy       = busy_q;
    assign accdone    = accdone_q;

endmodule

// File: tb/tb_acc_engine.sv
// Scoreboard bench for acc_engine: a 16-bit and an 8-bit accumulator instance
// share the command stimulus; each reads the same word memory model.
module tb_acc_engine;

    typedef struct {
        logic [15:0] res;
        int unsigned cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        accbypassA;
    logic [5:0]  startaddrA;
    logic [5:0]  datasizeA;

    logic [7:0]  mem_rdata, mem_rdata8;
    logic        mem_rd, mem_rd8;
    logic [5:0]  mem_addr, mem_addr8;
    logic [15:0] acc_result;
    logic [7:0]  acc_result8;
    logic        busy, busy8;
    logic        accdone, accdone8;

    logic [7:0]  mem [64];

    exp_t        res_q[$];
    exp_t        res8_q[$];
    logic [5:0]  addr_q[$];
    logic [5:0]  addr8_q[$];

    int unsigned cyc   = 0;
    int          total = 0;
    int          bad   = 0;

    acc_engine dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .accbypassA (accbypassA),
        .startaddrA (startaddrA),
        .datasizeA  (datasizeA),
        .mem_rdata  (mem_rdata),
        .mem_rd     (mem_rd),
        .mem_addr   (mem_addr),
        .acc_result (acc_result),
        .busy       (busy),
        .accdone    (accdone)
    );

    acc_engine #(.ACC_W(8)) dut8 (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .accbypassA (accbypassA),
        .startaddrA (startaddrA),
        .datasizeA  (datasizeA),
        .mem_rdata  (mem_rdata8),
        .mem_rd     (mem_rd8),
        .mem_addr   (mem_addr8),
        .acc_result (acc_result8),
        .busy       (busy8),
        .accdone    (accdone8)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: read data appears one cycle after the read enable.
    always @(posedge clk) begin
        if (mem_rd)  mem_rdata  <= mem[mem_addr];
        if (mem_rd8) mem_rdata8 <= mem[mem_addr8];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic flag_fail(input string name, input logic [31:0] act);
        total++;
        bad++;
        $display("FAIL %s: unexpected event, value %0h (cycle %0d)", name, act, cyc);
    endtask

    // Monitor: pops expected addresses on every read and expected results on
    // every accdone, comparing value and completion cycle.
    always @(negedge clk) begin : mon
        exp_t       e;
        logic [5:0] a;
        if (!reset) begin
            if (mem_rd) begin
                if (addr_q.size() == 0) flag_fail("rd_unexpected", mem_addr);
                else begin
                    a = addr_q.pop_front();
                    check("mem_addr", mem_addr, a);
                end
            end
            if (mem_rd8) begin
                if (addr8_q.size() == 0) flag_fail("rd8_unexpected", mem_addr8);
                else begin
                    a = addr8_q.pop_front();
                    check("mem_addr8", mem_addr8, a);
                end
            end
            if (accdone) begin
                if (res_q.size() == 0) flag_fail("accdone_unexpected", acc_result);
                else begin
                    e = res_q.pop_front();
                    check("acc_result", acc_result, e.res);
                    check("done_cycle", cyc, e.cyc);
                end
            end
            if (accdone8) begin
                if (res8_q.size() == 0) flag_fail("accdone8_unexpected", acc_result8);
                else begin
                    e = res8_q.pop_front();
                    check("acc_result8", acc_result8, e.res);
                    check("done_cycle8", cyc, e.cyc);
                end
            end
        end
    end

    // Issue one command; inputs are scrambled right after acceptance.
    task automatic issue(input logic byp, input logic [5:0] sa, input logic [5:0] sz,
                         input logic [15:0] exp);
        exp_t        e;
        int unsigned c;
        logic [5:0]  a;
        @(posedge clk); #1;
        cmd_valid  = 1'b1;
        accbypassA = byp;
        startaddrA = sa;
        datasizeA  = sz;
        c = cyc;
        e.res = exp;
        e.cyc = (byp || sz == 6'd0) ? c + 1 : c + sz + 2;
        res_q.push_back(e);
        e.res = {8'h00, exp[7:0]};
        res8_q.push_back(e);
        if (!byp) begin
            for (int unsigned k = 0; k < sz; k++) begin
                a = sa + 6'(k);
                addr_q.push_back(a);
                addr8_q.push_back(a);
            end
        end
        @(posedge clk); #1;
        cmd_valid  = 1'b0;
        accbypassA = ~byp;
        startaddrA = ~sa;
        datasizeA  = 6'd33;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200 && (res_q.size() != 0 || res8_q.size() != 0); i++)
            @(posedge clk);
        #1;
        if (res_q.size() != 0 || res8_q.size() != 0) begin
            flag_fail("done_timeout", res_q.size());
            res_q.delete(); res8_q.delete(); addr_q.delete(); addr8_q.delete();
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_mem_rd"},   mem_rd,     0);
        check({tag, "_mem_addr"}, mem_addr,   0);
        check({tag, "_acc"},      acc_result, 0);
        check({tag, "_busy"},     busy,       0);
        check({tag, "_accdone"},  accdone,    0);
        check({tag, "_acc8"},     acc_result8, 0);
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; accbypassA = 1'b0;
        startaddrA = '0; datasizeA = '0;
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("idle");

        // Bypass: accdone at T+1, no reads, result 0.
        issue(1'b1, 6'd9, 6'd5, 16'd0);
        check("byp_busy", busy, 1);
        wait_done();

        // Normal three-word job, then result and address hold.
        mem[4] = 8'd10; mem[5] = 8'd20; mem[6] = 8'd30;
        issue(1'b0, 6'd4, 6'd3, 16'd60);
        check("job_busy", busy, 1);
        wait_done();
        repeat (4) @(posedge clk);
        #1;
        check("hold_acc",    acc_result, 60);
        check("hold_addr",   mem_addr,   6);
        check("hold_rd",     mem_rd,     0);
        check("hold_busy",   busy,       0);
        check("hold_accdone", accdone,   0);

        // Address wrap through 63 -> 0.
        mem[62] = 8'hFF; mem[63] = 8'hFF; mem[0] = 8'hFF; mem[1] = 8'hFF;
        issue(1'b0, 6'd62, 6'd4, 16'h03FC);
        wait_done();

        // Size 0 without bypass.
        issue(1'b0, 6'd20, 6'd0, 16'd0);
        wait_done();

        // Five-word job with a command strobed while busy (must be ignored).
        for (int i = 0; i < 5; i++) mem[10 + i] = 8'(i + 1);
        issue(1'b0, 6'd10, 6'd5, 16'd15);
        cmd_valid = 1'b1; accbypassA = 1'b1; startaddrA = 6'd0; datasizeA = 6'd2;
        repeat (2) @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        wait_done();
        repeat (6) @(posedge clk);
        #1;
        check("after_ignored_acc", acc_result, 15);

        // Reset asserted in cycle T+2 of a five-word job.
        issue(1'b0, 6'd10, 6'd5, 16'd15);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        check_zero("midreset");
        res_q.delete(); res8_q.delete(); addr_q.delete(); addr8_q.delete();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("post_reset_acc", acc_result, 0);
        issue(1'b0, 6'd4, 6'd3, 16'd60);
        wait_done();

        // Three 0xFF words: the 8-bit accumulator wraps to 0xFD.
        issue(1'b0, 6'd62, 6'd3, 16'h02FD);
        wait_done();

        // Maximum size from address 63: 63, 0, 1, ..., 61 with mem[i] = i.
        for (int i = 0; i < 64; i++) mem[i] = 8'(i);
        issue(1'b0, 6'd63, 6'd63, 16'd1954);
        wait_done();
        repeat (3) @(posedge clk);
        #1;
        check("final_busy", busy, 0);
        check("addr_q_empty", addr_q.size() + addr8_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/acc_engine.md
Name: acc_engine

Overview:
- Consumes the latched accelerator command (bypass flag, 6-bit start address, 6-bit data size) produced by the accelerator command-latch front end.
- Walks a local word memory from startaddr for datasize words and sums the words into an accumulator.
- Returns a one-cycle accdone pulse to the front end, which re-arms it for the next command.

Parameters:
- DATA_W, 8, memory read-data width.
- ACC_W, 16, accumulator/result width; must be >= DATA_W.
- ADDR_W, 6, address and size width; fixed to match the command fields.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- cmd_valid  input  1  command strobe; sampled only in IDLE.
- accbypassA  input  1  bypass: perform no reads.
- startaddrA  input  ADDR_W  first read address.
- datasizeA  input  ADDR_W  number of words to read (0..63).
- mem_rdata  input  DATA_W  memory data; valid exactly 1 cycle after mem_rd.
- mem_rd  output  1  memory read enable.
- mem_addr  output  ADDR_W  memory read address.
- acc_result  output  ACC_W  accumulated sum.
- busy  output  1  high in every state except IDLE.
- accdone  output  1  one-cycle completion pulse.

Behaviour:
- Reset (synchronous, active-high, clock clk): state IDLE.
  - mem_rd=0, mem_addr=0, acc_result=0, busy=0, accdone=0.
  - Internal counter and read-valid pipeline flag are also cleared.
- All outputs are registered.
- States: IDLE, READ, DRAIN, DONE.
- IDLE:
  - cmd_valid=1 at cycle T captures startaddrA and datasizeA and clears acc_result to 0.
  - If accbypassA=1 or datasizeA=0, the next state is DONE.
  - Otherwise the next state is READ with remaining=datasizeA.
- READ, cycles T+1..T+N (N=datasize):
  - mem_rd=1.
  - mem_addr=startaddr+k for k=0..N-1, modulo 64 (63 wraps to 0).
  - remaining decrements each cycle. When the last address is issued, the next state is DRAIN.
- Read-valid flag: mem_rd delayed by one cycle.
  - In any cycle where the flag is 1, acc_result <= acc_result + zero-extended mem_rdata.
  - The sum is modulo 2^ACC_W; there is no saturation.
- DRAIN, cycle T+N+1:
  - mem_rd=0.
  - The last word is accumulated.
  - Next state is DONE.
- DONE:
  - Cycle T+N+2 on the normal path; cycle T+1 on the bypass or size-0 path.
  - accdone=1 for exactly one cycle and acc_result is final.
  - Next state is IDLE.
- Latency: N+2 cycles from cmd_valid to accdone; 1 cycle when bypassed or size 0.
- acc_result holds its final value until the next accepted command clears it.
- cmd_valid in any non-IDLE state is ignored (no queuing).
- Command inputs are sampled only at acceptance. Later changes have no effect.
- mem_addr holds its last value when mem_rd=0.
- Reset asserted mid-operation: return to reset values on the next edge.
  - No accdone is produced.
  - Data returned in the following cycle is not accumulated.
- Maximum size 63 with startaddr=63: addresses are 63, 0, 1, …, 61.

Decomposition:
- Shared package acc_pkg holds:
  - state enum {IDLE, READ, DRAIN, DONE};
  - ADDR_W=6 and the default DATA_W and ACC_W constants.
- One sub-module, acc_addr_gen: loads the start address and size, then on each enable outputs the address, increments it modulo 64, and flags the last address.
- The FSM and accumulator stay in acc_engine.

Test Plan:
- Reset, then idle: all outputs 0; cmd_valid with accbypassA=1 gives accdone=1 at T+1, no mem_rd ever, acc_result=0.
- startaddr=4, size=3, memory[4..6]=10,20,30:
  - mem_addr is 4,5,6 at T+1..T+3;
  - accdone at T+5 with acc_result=60, held afterwards.
- Wrap case, startaddr=62, size=4, all words 0xFF: addresses 62,63,0,1; acc_result=1020 (0x03FC).
- size=0 without bypass: accdone at T+1, no reads, acc_result=0; a second cmd_valid asserted while busy in a 5-word job is ignored (one accdone only).
- Reset asserted at T+2 of a 5-word job: all outputs 0 at the next edge, no accdone, and a new command afterwards runs normally.
- Overflow check with ACC_W=8, three words of 0xFF: acc_result=0xFD.
